// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared PS/2 definitions for the host transmitter and the
// keyboard receiver.
//   ps2_tx_state_t      : host transmit FSM states
//   PS2_OK/NACK/TIMEOUT : tx_status completion codes
//   PS2_*_CYCLES        : default bus timing at a 50 MHz clk_vga
//   ps2_odd_parity()    : parity bit making data+parity an odd count of ones
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_CLK,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [1:0] PS2_OK      = 2'd0;
  localparam logic [1:0] PS2_NACK    = 2'd1;
  localparam logic [1:0] PS2_TIMEOUT = 2'd2;

  localparam int PS2_INHIBIT_CYCLES = 6000;    // 120 us
  localparam int PS2_REQ_CYCLES     = 100;     // 2 us
  localparam int PS2_START_TIMEOUT  = 750000;  // 15 ms
  localparam int PS2_XFER_TIMEOUT   = 100000;  // 2 ms

  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync -- two-flop synchronizer for the PS/2 clock and data lines
// plus falling-edge detect on the synchronized clock.
//   clk_vga, reset_btn        : system clock, asynchronous active-high reset
//   ps2_clk_in, ps2_data_in   : raw bus levels
//   clk_sync, data_sync       : synchronized levels (reset to 1 = idle bus)
//   clk_fall                  : one-cycle strobe when clk_sync goes 1 -> 0
module ps2_line_sync (
  input  logic clk_vga,
  input  logic reset_btn,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] line_raw;
  logic [1:0] line_sync;
  logic       clk_prev_reg;

  assign line_raw = {ps2_data_in, ps2_clk_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk_vga or posedge reset_btn) begin
        if (reset_btn) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= line_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign line_sync[gi] = sync_reg;
    end
  endgenerate

  // Previous synchronized clock level; only the clock needs edge detection.
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      clk_prev_reg <= 1'b1;
    end else begin
      clk_prev_reg <= line_sync[0];
    end
  end

  assign clk_sync  = line_sync[0];
  assign data_sync = line_sync[1];
  assign clk_fall  = clk_prev_reg & ~line_sync[0];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 byte transmitter (e.g. LED commands).
//   clk_vga, reset_btn        : 50 MHz clock, asynchronous active-high reset
//   tx_valid, tx_data, tx_ready : byte request handshake (ready only in IDLE)
//   ps2_clk_in, ps2_data_in   : raw bus levels
//   ps2_clk_oe, ps2_data_oe   : 1 = pull the line low, 0 = release
//   busy                      : transfer in progress (receiver ignores bus)
//   tx_done, tx_status        : completion pulse and its result code
// Sequence: inhibit clock, request-to-send (data low), release clock, then
// shift out 8 data bits, odd parity and stop on device falling edges, sample
// the device acknowledge, and wait for the bus to go idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int REQ_CYCLES     = PS2_REQ_CYCLES,
  parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int XFER_TIMEOUT   = PS2_XFER_TIMEOUT
) (
  input  logic       clk_vga,
  input  logic       reset_btn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic [1:0] tx_status
);

  // One phase counter times INHIBIT, REQ and the WAIT_CLK start timeout.
  localparam int PHASE_MAX = (START_TIMEOUT > INHIBIT_CYCLES)
                           ? ((START_TIMEOUT > REQ_CYCLES) ? START_TIMEOUT : REQ_CYCLES)
                           : ((INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES);
  localparam int PW = $clog2(PHASE_MAX + 1);

  localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] REQ_LAST     = PW'(REQ_CYCLES - 1);
  localparam logic [PW-1:0] START_LAST   = PW'(START_TIMEOUT - 1);
  localparam logic [19:0]   XFER_LAST    = 20'(XFER_TIMEOUT - 1);

  ps2_tx_state_t state_reg;
  logic [PW-1:0] phase_cnt_reg;
  logic [19:0]   xfer_cnt_reg;
  logic [3:0]    bit_cnt_reg;     // device falling edges seen, 0..11
  logic [8:0]    shift_reg;       // {parity, data}
  logic          nack_reg;
  logic          clk_oe_reg;
  logic          data_oe_reg;
  logic          tx_done_reg;
  logic [1:0]    tx_status_reg;

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  ps2_line_sync u_line_sync (
    .clk_vga     (clk_vga),
    .reset_btn   (reset_btn),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .clk_fall    (clk_fall)
  );

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      state_reg     <= ST_IDLE;
      phase_cnt_reg <= '0;
      xfer_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      nack_reg      <= 1'b0;
      clk_oe_reg    <= 1'b0;
      data_oe_reg   <= 1'b0;
      tx_done_reg   <= 1'b0;
      tx_status_reg <= PS2_OK;
    end else begin
      tx_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (tx_valid) begin
            shift_reg     <= {ps2_odd_parity(tx_data), tx_data};
            bit_cnt_reg   <= '0;
            phase_cnt_reg <= '0;
            nack_reg      <= 1'b0;
            clk_oe_reg    <= 1'b1;
            state_reg     <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (phase_cnt_reg == INHIBIT_LAST) begin
            phase_cnt_reg <= '0;
            data_oe_reg   <= 1'b1;   // start bit, clock still held
            state_reg     <= ST_REQ;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end

        ST_REQ: begin
          if (phase_cnt_reg == REQ_LAST) begin
            phase_cnt_reg <= '0;
            clk_oe_reg    <= 1'b0;   // hand the clock to the device
            state_reg     <= ST_WAIT_CLK;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end

        ST_WAIT_CLK: begin
          if (clk_fall) begin
            data_oe_reg  <= ~shift_reg[0];
            bit_cnt_reg  <= 4'd1;
            xfer_cnt_reg <= '0;
            state_reg    <= ST_SEND;
          end else if (phase_cnt_reg == START_LAST) begin
            data_oe_reg   <= 1'b0;
            tx_done_reg   <= 1'b1;
            tx_status_reg <= PS2_TIMEOUT;
            state_reg     <= ST_IDLE;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end

        ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
          if (xfer_cnt_reg == XFER_LAST) begin
            // Timeout bypasses WAIT_IDLE; clk_oe is already 0 here.
            clk_oe_reg    <= 1'b0;
            data_oe_reg   <= 1'b0;
            tx_done_reg   <= 1'b1;
            tx_status_reg <= PS2_TIMEOUT;
            state_reg     <= ST_IDLE;
          end else begin
            xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
            if (state_reg == ST_SEND) begin
              if (clk_fall) begin
                if (bit_cnt_reg == 4'd9) begin
                  data_oe_reg <= 1'b0;   // stop bit: release data
                  bit_cnt_reg <= 4'd10;
                  state_reg   <= ST_ACK;
                end else begin
                  // Edges 2..9 carry data[1..7] then parity (shift_reg[8]).
                  data_oe_reg <= ~shift_reg[bit_cnt_reg];
                  bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
              end
            end else if (state_reg == ST_ACK) begin
              if (clk_fall) begin
                nack_reg    <= data_sync;
                bit_cnt_reg <= 4'd11;
                state_reg   <= ST_WAIT_IDLE;
              end
            end else begin
              // Further edges here are ignored; only bus idle matters.
              if (clk_sync && data_sync) begin
                tx_done_reg   <= 1'b1;
                tx_status_reg <= nack_reg ? PS2_NACK : PS2_OK;
                state_reg     <= ST_IDLE;
              end
            end
          end
        end

        default: begin
          clk_oe_reg  <= 1'b0;
          data_oe_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign tx_done     = tx_done_reg;
  assign tx_status   = tx_status_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- self-checking bench for ps2_host_tx with a behavioural
// PS/2 device on a wired-AND bus. Timing parameters are scaled down so the
// whole run stays short; the device clocks with a 2*H-cycle bit period.
module tb_ps2_host_tx;

  localparam int I = 60;     // INHIBIT_CYCLES
  localparam int R = 10;     // REQ_CYCLES
  localparam int S = 3000;   // START_TIMEOUT
  localparam int X = 2000;   // XFER_TIMEOUT
  localparam int H = 40;     // device half bit period

  logic       clk_vga = 1'b0;
  logic       reset_btn = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic [1:0] tx_status;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  // Open-drain bus: either side can only pull low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (I),
    .REQ_CYCLES     (R),
    .START_TIMEOUT  (S),
    .XFER_TIMEOUT   (X)
  ) dut (
    .clk_vga     (clk_vga),
    .reset_btn   (reset_btn),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_status   (tx_status)
  );

  always #5 clk_vga = ~clk_vga;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cyc = 0;
  int first_fall_cyc = 0;
  int viol = 0;
  logic [1:0] last_status = 2'd0;
  logic prev_c = 1'b0;
  logic prev_d = 1'b0;

  always @(posedge clk_vga) cyc <= cyc + 1;

  // Completion capture and bus invariants (one oe change per cycle,
  // clock never held while idle).
  always @(negedge clk_vga) begin
    if (tx_done) begin
      done_cnt++;
      last_status = tx_status;
      done_cyc = cyc;
    end
    if (!reset_btn) begin
      if ((ps2_clk_oe != prev_c) && (ps2_data_oe != prev_d)) viol++;
      if (ps2_clk_oe && !busy) viol++;
    end
    prev_c = ps2_clk_oe;
    prev_d = ps2_data_oe;
  end

  // Reference: frame the device should see for a byte.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk_vga);
    while (!tx_ready && t < 100) begin
      @(negedge clk_vga);
      t++;
    end
    tx_valid = 1'b1;
    tx_data  = b;
    @(posedge clk_vga);
    @(negedge clk_vga);
    acc_cyc  = cyc;
    tx_valid = 1'b0;
    tx_data  = $urandom;
  endtask

  // Device: waits for request-to-send, then generates up to n_edges falling
  // edges, sampling the data line in each high phase; edge 11 is the ack.
  task automatic device(input int n_edges, input bit ack,
                        output logic [10:0] frame, output bit ok);
    int t;
    ok = 1'b1;
    frame = '1;
    t = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 1000) begin
      @(negedge clk_vga);
      t++;
    end
    if (t >= 1000) begin
      ok = 1'b0;
      return;
    end
    repeat (H) @(negedge clk_vga);
    frame[0] = ps2_data_in;
    for (int k = 1; k <= n_edges && k <= 10; k++) begin
      if (k == 1) first_fall_cyc = cyc;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk_vga);
      dev_clk = 1'b1;
      repeat (H / 2) @(negedge clk_vga);
      frame[k] = ps2_data_in;
      repeat (H / 2) @(negedge clk_vga);
    end
    if (n_edges >= 11) begin
      if (ack) dev_data = 1'b0;
      repeat (4) @(negedge clk_vga);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk_vga);
      dev_clk = 1'b1;
      repeat (4) @(negedge clk_vga);
      dev_data = 1'b1;
      repeat (H) @(negedge clk_vga);
    end
  endtask

  task automatic wait_done(input int start, input int budget, output bit ok);
    int t;
    t = 0;
    while (done_cnt == start && t < budget) begin
      @(negedge clk_vga);
      t++;
    end
    ok = (done_cnt != start);
  endtask

  task automatic test_reset();
    @(negedge clk_vga);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_status} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got clk_oe=%b data_oe=%b busy=%b done=%b status=%0d want all 0",
               ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_status);
    end
    reset_btn = 1'b0;
    @(negedge clk_vga);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", tx_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_frame(input logic [7:0] b, input bit ack);
    logic [10:0] frame;
    logic [10:0] exp;
    bit ok, dok;
    int start;
    start = done_cnt;
    exp = model_frame(b);
    send_byte(b);
    device(11, ack, frame, dok);
    wait_done(start, 500, ok);
    checks++;
    if (!dok || !ok) begin
      errors++;
      $display("FAIL frame_%02h_handshake got rts=%b done=%b want 1 1", b, dok, ok);
    end
    checks++;
    if (frame !== exp) begin
      errors++;
      $display("FAIL frame_%02h_bits got %b want %b", b, frame, exp);
    end
    checks++;
    if (done_cnt !== start + 1 || last_status !== (ack ? 2'd0 : 2'd1)) begin
      errors++;
      $display("FAIL frame_%02h_status got pulses=%0d status=%0d want 1 %0d",
               b, done_cnt - start, last_status, ack ? 0 : 1);
    end
    $display("tx %02h ack=%0d frame=%b status=%0d", b, ack, frame, last_status);
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit a;
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      a = 1'($urandom_range(0, 1));
      test_frame(b, a);
    end
  endtask

  task automatic test_start_timeout();
    int n, start;
    bit ok;
    start = done_cnt;
    send_byte(8'hF4);
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 10000) begin
      n++;
      @(negedge clk_vga);
    end
    checks++;
    if (n !== I) begin
      errors++;
      $display("FAIL inhibit_len got %0d want %0d", n, I);
    end
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && n < 10000) begin
      n++;
      @(negedge clk_vga);
    end
    checks++;
    if (n !== R) begin
      errors++;
      $display("FAIL req_len got %0d want %0d", n, R);
    end
    wait_done(start, S + 200, ok);
    checks++;
    if (!ok || (done_cyc - acc_cyc) !== I + R + S || last_status !== 2'd2) begin
      errors++;
      $display("FAIL start_timeout got done=%b delay=%0d status=%0d want 1 %0d 2",
               ok, done_cyc - acc_cyc, last_status, I + R + S);
    end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
      errors++;
      $display("FAIL start_timeout_release got clk_oe=%b data_oe=%b ready=%b want 0 0 1",
               ps2_clk_oe, ps2_data_oe, tx_ready);
    end
    $display("tx F4 no device: status=%0d delay=%0d", last_status, done_cyc - acc_cyc);
  endtask

  task automatic test_xfer_timeout();
    logic [10:0] frame;
    bit ok, dok;
    int start, d;
    logic [7:0] b;
    b = 8'($urandom);
    start = done_cnt;
    send_byte(b);
    device(5, 1'b1, frame, dok);
    wait_done(start, X + 200, ok);
    d = done_cyc - first_fall_cyc;
    // The 2-flop sync plus edge register put the host's first-edge event
    // about 3 cycles after the device drives the clock low.
    checks++;
    if (!dok || !ok || last_status !== 2'd2 || d < X + 2 || d > X + 4) begin
      errors++;
      $display("FAIL xfer_timeout got rts=%b done=%b status=%0d delay=%0d want 1 1 2 %0d..%0d",
               dok, ok, last_status, d, X + 2, X + 4);
    end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
      errors++;
      $display("FAIL xfer_timeout_release got clk_oe=%b data_oe=%b ready=%b want 0 0 1",
               ps2_clk_oe, ps2_data_oe, tx_ready);
    end
    $display("tx %02h 5 edges: status=%0d delay=%0d", b, last_status, d);
  endtask

  task automatic test_reset_mid();
    logic [10:0] frame;
    bit dok;
    int start;
    start = done_cnt;
    send_byte(8'hED);
    device(5, 1'b1, frame, dok);
    // After edge 5 the host drives data bit 4 of 0xED, which is 0.
    checks++;
    if (!dok || ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre got rts=%b data_oe=%b busy=%b want 1 1 1",
               dok, ps2_data_oe, busy);
    end
    @(posedge clk_vga);
    #2 reset_btn = 1'b1;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_release got clk_oe=%b data_oe=%b busy=%b want 0 0 0",
               ps2_clk_oe, ps2_data_oe, busy);
    end
    repeat (3) @(negedge clk_vga);
    reset_btn = 1'b0;
    repeat (50) @(negedge clk_vga);
    checks++;
    if (done_cnt !== start || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_nodone got pulses=%0d ready=%b want 0 1",
               done_cnt - start, tx_ready);
    end
    $display("reset during bit 4: pulses=%0d", done_cnt - start);
    test_frame(8'hED, 1'b1);
  endtask

  task automatic test_ignore_busy();
    logic [10:0] frame;
    bit dok;
    int start, gaps, t;
    start = done_cnt;
    gaps = 0;
    send_byte(8'hED);
    fork
      device(11, 1'b1, frame, dok);
      begin
        repeat (300) @(negedge clk_vga);
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        repeat (3) @(negedge clk_vga);
        tx_valid = 1'b0;
      end
      begin
        t = 0;
        while (done_cnt == start && t < 3000) begin
          if (!busy && !tx_done) gaps++;
          @(negedge clk_vga);
          t++;
        end
      end
    join
    checks++;
    if (!dok || frame !== model_frame(8'hED)) begin
      errors++;
      $display("FAIL ignore_frame got rts=%b frame=%b want 1 %b", dok, frame, model_frame(8'hED));
    end
    checks++;
    if (gaps !== 0 || done_cnt !== start + 1 || last_status !== 2'd0) begin
      errors++;
      $display("FAIL ignore_busy got gaps=%0d pulses=%0d status=%0d want 0 1 0",
               gaps, done_cnt - start, last_status);
    end
    repeat (20) @(negedge clk_vga);
    checks++;
    if (busy !== 1'b0 || done_cnt !== start + 1) begin
      errors++;
      $display("FAIL ignore_no_second got busy=%b pulses=%0d want 0 1", busy, done_cnt - start);
    end
    $display("tx ED with AA while busy: frame=%b gaps=%0d", frame, gaps);
  endtask

  task automatic test_invariants();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL oe_invariants got %0d violations want 0", viol);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_vga);
    test_reset();
    test_frame(8'hED, 1'b1);
    test_frame(8'h02, 1'b0);
    test_random();
    test_start_timeout();
    test_xfer_timeout();
    test_reset_mid();
    test_ignore_busy();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 6000, is the clock-low inhibit time in clk_vga cycles (120 us at 50 MHz).
REQ-002 Parameter REQ_CYCLES, default 100, is the data-low hold time before the clock is released.
REQ-003 Parameter START_TIMEOUT, default 750000, is the maximum wait from clock release to the first device falling edge (15 ms).
REQ-004 Parameter XFER_TIMEOUT, default 100000, is the maximum time from the first falling edge to bus idle (2 ms).
REQ-005 Ports, clock and reset first: clk_vga in 1, 50 MHz pixel/system clock; reset_btn in 1, asynchronous, active-high reset.
REQ-006 tx_valid in 1, command byte request; tx_data in 8, byte to send (e.g. 0xED LED command); tx_ready out 1, high only in IDLE.
REQ-007 ps2_clk_in in 1 and ps2_data_in in 1, raw bus levels; ps2_clk_oe out 1 and ps2_data_oe out 1, 1 = drive line low (open-drain), 0 = release.
REQ-008 busy out 1, high in every state except IDLE, so the keyboard receiver ignores the bus; tx_done out 1, single-cycle completion pulse; tx_status out 2, valid with tx_done.

Function
REQ-009 A transfer starts when tx_valid && tx_ready on a rising clk_vga edge; tx_data is latched and odd parity is computed at that edge; tx_valid while busy is ignored.
REQ-010 ps2_clk_in and ps2_data_in pass through a 2-flop synchronizer; a device falling edge is synced clock 1 -> 0.
REQ-011 States: IDLE, INHIBIT, REQ, WAIT_CLK, SEND, ACK, WAIT_IDLE.
REQ-012 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-013 REQ: clk_oe=1, data_oe=1 (start bit) for REQ_CYCLES cycles, then WAIT_CLK with clk_oe=0 and data_oe still 1.
REQ-014 WAIT_CLK: first falling edge -> SEND and data_oe=~tx_data[0]; no edge within START_TIMEOUT cycles -> timeout.
REQ-015 SEND: falling edges 2..8 drive data_oe=~tx_data[1..7], edge 9 drives parity, edge 10 sets data_oe=0 (stop bit) and enters ACK.
REQ-016 Each new data_oe value takes effect on the cycle after the synced falling edge is detected.
REQ-017 ACK: on the 11th falling edge, sample synced data; low = acknowledged, high = NACK; then WAIT_IDLE.
REQ-018 WAIT_IDLE: wait until synced clock and data are both high, then pulse tx_done for one cycle and return to IDLE.
REQ-019 tx_status: 2'd0 ack OK, 2'd1 NACK, 2'd2 timeout; it holds its value until the next tx_done.
REQ-020 A 20-bit transfer timer starts at the first falling edge; reaching XFER_TIMEOUT in SEND, ACK or WAIT_IDLE -> timeout.
REQ-021 Timeout releases both lines in the same cycle, pulses tx_done with status 2, and returns to IDLE; it skips WAIT_IDLE.
REQ-022 Only one of clk_oe and data_oe changes per cycle; clk_oe is never 1 outside INHIBIT and REQ.
REQ-023 The bit counter is 4 bits (0..11) and does not wrap; extra falling edges in WAIT_IDLE are ignored.

Reset
REQ-024 On reset_btn high, asynchronously: state=IDLE, clk_oe=0, data_oe=0, busy=0, tx_done=0, tx_status=0, and all counters, the shift register and the synchronizers are cleared (synchronizer flops set to 1 = idle bus).
REQ-025 Reset mid-transfer releases both lines immediately; no tx_done is produced for the aborted byte.
REQ-026 tx_ready is asserted in the first cycle after reset deasserts.

Structure
REQ-027 The shared package ps2_pkg holds the state enum, the tx_status codes (PS2_OK, PS2_NACK, PS2_TIMEOUT) and the default timing constants.
REQ-028 One sub-module, ps2_line_sync, provides the 2-flop synchronizer and falling-edge detect for both lines; the receiver reuses it.
REQ-029 The enclosing top uses the oe outputs to drive tri-states: each line is driven low when its oe is 1, else high-Z.

Verification
REQ-030 Send 0xED, device model clocks at 12.5 kHz and acks -> start bit then data bits 1,0,1,1,0,1,1,1 LSB-first, parity 1, stop 1; tx_done with status 0.
REQ-031 Send 0x02, device leaves data high at ACK -> parity 0 on the wire; tx_done with status 1.
REQ-032 Send 0xF4, device never clocks -> clk_oe low for exactly 6000 cycles; tx_done with status 2 exactly 6000+100+750000 cycles after acceptance; both lines released.
REQ-033 Device stops after 5 falling edges -> status 2 when the transfer timer reaches 100000; tx_ready high the next cycle.
REQ-034 Assert reset_btn during SEND bit 4 -> oe outputs 0 within the same cycle and no tx_done; a following 0xED transfer succeeds.
REQ-035 Pulse tx_valid with 0xAA while busy -> ignored; the in-flight byte is transmitted unchanged; busy high throughout.
